// File: rtl/avalon_pio_pkg.sv
// ---------------------------------------------------------------------------
// avalon_pio_pkg
// Shared definitions for the Avalon-MM PIO initiator:
//   - avm_state_e      : transfer sequencing states (IDLE, BUS, RESP)
//   - AVM_ADDR_W_DEF   : default bus word-address width
//   - AVM_DATA_W_DEF   : default bus data width
//   - AVM_TIMEOUT_DEF  : default BUS-phase abort limit (used with AVM_TIMEOUT_EN)
//   - avm_strobes()    : helper deriving the active-low strobe pair for a direction
// ---------------------------------------------------------------------------
package avalon_pio_pkg;

    localparam int AVM_ADDR_W_DEF  = 4;
    localparam int AVM_DATA_W_DEF  = 32;
    localparam int AVM_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } avm_state_e;

    // Returns {read_n, write_n} for an active transfer; exactly one bit is low.
    function automatic logic [1:0] avm_strobes(input logic is_write);
        avm_strobes = is_write ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/avm_timeout_counter.sv
// ---------------------------------------------------------------------------
// avm_timeout_counter
// Counts stalled BUS cycles for the Avalon PIO initiator and flags the cycle
// whose stall would bring the count up to LIMIT. Only instantiated when the
// AVM_TIMEOUT_EN macro is defined.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high reset
//   clear    in   zero the count (asserted when a transfer enters BUS)
//   enable   in   count this cycle (BUS with waitrequest high)
//   expired  out  this enabled cycle makes the count reach LIMIT
// ---------------------------------------------------------------------------
module avm_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_r;

    // Stall counter: cleared on reset or entry into BUS, advanced on each stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // The stall being counted now is the LIMIT-th one, so the abort lands on
    // the edge that ends the LIMIT-th stalled BUS cycle.
    assign expired = enable & (count_r == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/avalon_pio_master.sv
// ---------------------------------------------------------------------------
// avalon_pio_master
// Avalon-MM initiator for PIO-style slaves. Takes one command on a
// valid/ready interface, runs one single-beat transfer honouring waitrequest,
// and returns one response on a valid/ready interface. One transfer at a time.
// Optional feature macro: AVM_TIMEOUT_EN -- aborts a BUS phase stalled for
// TIMEOUT_CYCLES cycles and reports it through rsp_error.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready                 command handshake (ready only in IDLE)
//   cmd_write/cmd_address/cmd_writedata command contents
//   rsp_valid/rsp_ready                 response handshake
//   rsp_readdata/rsp_error              response contents
//   address/chipselect/read_n/write_n   Avalon request (all registered)
//   writedata                           Avalon write data (registered)
//   readdata/waitrequest                Avalon slave return
// ---------------------------------------------------------------------------
module avalon_pio_master
    import avalon_pio_pkg::*;
#(
    parameter int ADDR_W         = AVM_ADDR_W_DEF,
    parameter int DATA_W         = AVM_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = AVM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              read_n,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    input  logic              waitrequest
);

    avm_state_e        state_r;
    logic              dir_write_r;
    logic [ADDR_W-1:0] address_r;
    logic [DATA_W-1:0] writedata_r;
    logic              chipselect_r;
    logic              read_n_r;
    logic              write_n_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_readdata_r;
    logic              rsp_error_r;
    logic              timeout_expired_s;

`ifdef AVM_TIMEOUT_EN
    logic accept_s;
    logic stall_s;

    assign accept_s = (state_r == IDLE) & cmd_valid;
    assign stall_s  = (state_r == BUS) & waitrequest;

    avm_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_s),
        .enable  (stall_s),
        .expired (timeout_expired_s)
    );
`else
    // No abort path in this build; the term is constant 0 and only keeps the
    // parameter referenced so both builds share one interface.
    assign timeout_expired_s = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    // Transfer sequencer with all bus and response outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            dir_write_r    <= 1'b0;
            address_r      <= {ADDR_W{1'b0}};
            writedata_r    <= {DATA_W{1'b0}};
            chipselect_r   <= 1'b0;
            read_n_r       <= 1'b1;
            write_n_r      <= 1'b1;
            rsp_valid_r    <= 1'b0;
            rsp_readdata_r <= {DATA_W{1'b0}};
            rsp_error_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        address_r               <= cmd_address;
                        writedata_r             <= cmd_writedata;
                        dir_write_r             <= cmd_write;
                        chipselect_r            <= 1'b1;
                        {read_n_r, write_n_r}   <= avm_strobes(cmd_write);
                        state_r                 <= BUS;
                    end
                end
                BUS: begin
                    // A release in the limit cycle still counts as a normal
                    // completion, so waitrequest is tested before the timeout.
                    if (!waitrequest) begin
                        chipselect_r   <= 1'b0;
                        read_n_r       <= 1'b1;
                        write_n_r      <= 1'b1;
                        rsp_valid_r    <= 1'b1;
                        rsp_readdata_r <= dir_write_r ? {DATA_W{1'b0}} : readdata;
                        rsp_error_r    <= 1'b0;
                        state_r        <= RESP;
                    end else if (timeout_expired_s) begin
                        chipselect_r   <= 1'b0;
                        read_n_r       <= 1'b1;
                        write_n_r      <= 1'b1;
                        rsp_valid_r    <= 1'b1;
                        rsp_readdata_r <= {DATA_W{1'b0}};
                        rsp_error_r    <= 1'b1;
                        state_r        <= RESP;
                    end
                end
                RESP: begin
                    // Returning to IDLE here means no command can be taken in
                    // the handshake cycle itself.
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    chipselect_r <= 1'b0;
                    read_n_r     <= 1'b1;
                    write_n_r    <= 1'b1;
                    rsp_valid_r  <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = (state_r == IDLE) & ~reset;
    assign address      = address_r;
    assign writedata    = writedata_r;
    assign chipselect   = chipselect_r;
    assign read_n       = read_n_r;
    assign write_n      = write_n_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_readdata = rsp_readdata_r;
    assign rsp_error    = rsp_error_r;

endmodule
